// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C master between two clients (0 and 1).
//   - Level-sensitive requests on cN_start; round-robin when both ask at once.
//   - The grant goes live one cycle after the FSM enters GRANTN.
//   - After every grant, GAP_CYCLES idle cycles hold i2c_start low so the master can issue STOP.
//   - An optional watchdog (TIMEOUT>0) aborts a grant that runs too long.
//     The aborted client must drop its request and raise it again before it can be served.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cN_slave_addr/rw/write_data/    client N transaction fields and request level
//   nbytes/start
//   cN_read_data                    rx byte broadcast to both clients
//   cN_tx_data_req/rx_data_ready    master handshakes, gated by the client N grant
//   cN_grant, cN_timeout            ownership flag, one-cycle watchdog abort pulse
//   i2c_*                           muxed master request fields and returned master signals
module i2c_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] c0_slave_addr,
    input  logic       c0_rw,
    input  logic [7:0] c0_write_data,
    input  logic [7:0] c0_nbytes,
    input  logic       c0_start,
    output logic [7:0] c0_read_data,
    output logic       c0_tx_data_req,
    output logic       c0_rx_data_ready,
    output logic       c0_grant,
    output logic       c0_timeout,
    input  logic [6:0] c1_slave_addr,
    input  logic       c1_rw,
    input  logic [7:0] c1_write_data,
    input  logic [7:0] c1_nbytes,
    input  logic       c1_start,
    output logic [7:0] c1_read_data,
    output logic       c1_tx_data_req,
    output logic       c1_rx_data_ready,
    output logic       c1_grant,
    output logic       c1_timeout,
    output logic [6:0] i2c_slave_addr,
    output logic       i2c_rw,
    output logic [7:0] i2c_write_data,
    output logic [7:0] i2c_nbytes,
    output logic       i2c_start,
    input  logic [7:0] i2c_read_data,
    input  logic       i2c_tx_data_req,
    input  logic       i2c_rx_data_ready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    localparam logic [7:0]  GAP_LOAD = 8'(GAP_CYCLES);
    localparam logic [23:0] WD_LAST  = 24'(TIMEOUT - 1);
    localparam bit          WD_EN    = (TIMEOUT != 0);

    state_t      r_state;
    state_t      w_next;
    logic        r_last;     // 1: client 1 was granted last, so client 0 wins a tie
    logic [1:0]  r_armed;
    logic        r_live;     // grant output becomes visible one cycle after GRANTN entry
    logic [7:0]  r_gap;
    logic [23:0] r_wd;
    logic        w_req0;
    logic        w_req1;
    logic        w_expire;
    logic        w_to0;
    logic        w_to1;
    logic        w_g0;
    logic        w_g1;

    assign w_req0   = c0_start & r_armed[0];
    assign w_req1   = c1_start & r_armed[1];
    assign w_expire = WD_EN && (r_wd == WD_LAST);
    // A release in the expiry cycle wins over the watchdog, so start must still be high.
    assign w_to0    = (r_state == S_GRANT0) && c0_start && w_expire;
    assign w_to1    = (r_state == S_GRANT1) && c1_start && w_expire;
    assign w_g0     = (r_state == S_GRANT0) && r_live;
    assign w_g1     = (r_state == S_GRANT1) && r_live;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: arbitration, release, watchdog abort and gap countdown.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_next = r_last ? S_GRANT0 : S_GRANT1;
                end else if (w_req0) begin
                    w_next = S_GRANT0;
                end else if (w_req1) begin
                    w_next = S_GRANT1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_GRANT0: begin
                if (!c0_start || w_to0) begin
                    w_next = S_GAP;
                end else begin
                    w_next = S_GRANT0;
                end
            end
            S_GRANT1: begin
                if (!c1_start || w_to1) begin
                    w_next = S_GAP;
                end else begin
                    w_next = S_GRANT1;
                end
            end
            S_GAP: begin
                if (r_gap <= 8'd1) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_GAP;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Auxiliary state: grant-live flag, gap and watchdog counters, round-robin and armed flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last  <= 1'b1;
            r_armed <= 2'b11;
            r_live  <= 1'b0;
            r_gap   <= 8'd0;
            r_wd    <= 24'd0;
        end else begin
            r_live <= (r_state == S_GRANT0) || (r_state == S_GRANT1);

            if ((w_next == S_GAP) && (r_state != S_GAP)) begin
                r_gap <= GAP_LOAD;
            end else if ((r_state == S_GAP) && (r_gap != 8'd0)) begin
                r_gap <= r_gap - 8'd1;
            end else begin
                r_gap <= r_gap;
            end

            // Counts cycles spent in the current grant; cleared on any other state.
            if (((r_state == S_GRANT0) || (r_state == S_GRANT1)) && (w_next == r_state)) begin
                r_wd <= r_wd + 24'd1;
            end else begin
                r_wd <= 24'd0;
            end

            if ((r_state == S_IDLE) && (w_next == S_GRANT0)) begin
                r_last <= 1'b0;
            end else if ((r_state == S_IDLE) && (w_next == S_GRANT1)) begin
                r_last <= 1'b1;
            end else begin
                r_last <= r_last;
            end

            if (!c0_start) begin
                r_armed[0] <= 1'b1;
            end else if (w_to0) begin
                r_armed[0] <= 1'b0;
            end else begin
                r_armed[0] <= r_armed[0];
            end

            if (!c1_start) begin
                r_armed[1] <= 1'b1;
            end else if (w_to1) begin
                r_armed[1] <= 1'b0;
            end else begin
                r_armed[1] <= r_armed[1];
            end
        end
    end

    // Output decode: mux the granted client onto the master and gate the master returns.
    always_comb begin
        c0_read_data     = i2c_read_data;
        c1_read_data     = i2c_read_data;
        c0_grant         = w_g0;
        c1_grant         = w_g1;
        c0_timeout       = w_to0;
        c1_timeout       = w_to1;
        c0_tx_data_req   = w_g0 & i2c_tx_data_req;
        c1_tx_data_req   = w_g1 & i2c_tx_data_req;
        c0_rx_data_ready = w_g0 & i2c_rx_data_ready;
        c1_rx_data_ready = w_g1 & i2c_rx_data_ready;
        i2c_slave_addr   = 7'd0;
        i2c_rw           = 1'b0;
        i2c_write_data   = 8'd0;
        i2c_nbytes       = 8'd0;
        i2c_start        = 1'b0;
        if (w_g0) begin
            i2c_slave_addr = c0_slave_addr;
            i2c_rw         = c0_rw;
            i2c_write_data = c0_write_data;
            i2c_nbytes     = c0_nbytes;
            i2c_start      = c0_start;
        end else if (w_g1) begin
            i2c_slave_addr = c1_slave_addr;
            i2c_rw         = c1_rw;
            i2c_write_data = c1_write_data;
            i2c_nbytes     = c1_nbytes;
            i2c_start      = c1_start;
        end else begin
            i2c_start      = 1'b0;
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
module tb_i2c_arbiter;

    logic       clk;
    logic       reset;
    logic [6:0] c0_slave_addr, c1_slave_addr;
    logic       c0_rw, c1_rw;
    logic [7:0] c0_write_data, c1_write_data;
    logic [7:0] c0_nbytes, c1_nbytes;
    logic       c0_start, c1_start;
    logic [7:0] c0_read_data, c1_read_data;
    logic       c0_tx_data_req, c1_tx_data_req;
    logic       c0_rx_data_ready, c1_rx_data_ready;
    logic       c0_grant, c1_grant;
    logic       c0_timeout, c1_timeout;
    logic [6:0] i2c_slave_addr;
    logic       i2c_rw;
    logic [7:0] i2c_write_data;
    logic [7:0] i2c_nbytes;
    logic       i2c_start;
    logic [7:0] i2c_read_data;
    logic       i2c_tx_data_req;
    logic       i2c_rx_data_ready;

    i2c_arbiter #(.GAP_CYCLES(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .c0_slave_addr(c0_slave_addr), .c0_rw(c0_rw), .c0_write_data(c0_write_data),
        .c0_nbytes(c0_nbytes), .c0_start(c0_start), .c0_read_data(c0_read_data),
        .c0_tx_data_req(c0_tx_data_req), .c0_rx_data_ready(c0_rx_data_ready),
        .c0_grant(c0_grant), .c0_timeout(c0_timeout),
        .c1_slave_addr(c1_slave_addr), .c1_rw(c1_rw), .c1_write_data(c1_write_data),
        .c1_nbytes(c1_nbytes), .c1_start(c1_start), .c1_read_data(c1_read_data),
        .c1_tx_data_req(c1_tx_data_req), .c1_rx_data_ready(c1_rx_data_ready),
        .c1_grant(c1_grant), .c1_timeout(c1_timeout),
        .i2c_slave_addr(i2c_slave_addr), .i2c_rw(i2c_rw), .i2c_write_data(i2c_write_data),
        .i2c_nbytes(i2c_nbytes), .i2c_start(i2c_start), .i2c_read_data(i2c_read_data),
        .i2c_tx_data_req(i2c_tx_data_req), .i2c_rx_data_ready(i2c_rx_data_ready)
    );

    // Expected DUT events: kind 0 = grant rising, kind 1 = timeout pulse.
    typedef struct {
        int kind;
        int client;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic p0 = 1'b0;
    logic p1 = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL tb_watchdog: simulation ran past its time limit");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int client, input int at);
        exp_t e;
        e.kind = kind;
        e.client = client;
        e.cyc = at;
        q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input int client);
        exp_t e;
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d client=%0d cycle=%0d expected no event",
                     kind, client, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.client != client || e.cyc != cyc) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d client=%0d cycle=%0d expected kind=%0d client=%0d cycle=%0d",
                         kind, client, cyc, e.kind, e.client, e.cyc);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever a grant rises or a timeout pulse appears.
    always @(negedge clk) begin
        if (!reset) begin
            if (c0_grant && !p0) sb_pop(0, 0);
            if (c1_grant && !p1) sb_pop(0, 1);
            if (c0_timeout) sb_pop(1, 0);
            if (c1_timeout) sb_pop(1, 1);
        end
        p0 = c0_grant;
        p1 = c1_grant;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int r;
    int s;
    int t;
    int bad;

    initial begin
        reset = 1'b1;
        c0_slave_addr = 7'h50; c0_rw = 1'b0; c0_write_data = 8'h11; c0_nbytes = 8'd2;
        c1_slave_addr = 7'h2A; c1_rw = 1'b1; c1_write_data = 8'h00; c1_nbytes = 8'd3;
        c0_start = 1'b1; c1_start = 1'b1;
        i2c_read_data = 8'h3C; i2c_tx_data_req = 1'b1; i2c_rx_data_ready = 1'b1;
        tick(2);
        // Reset state: everything low except the read data broadcast.
        check("rst_c0_grant", c0_grant, 1'b0);
        check("rst_c1_grant", c1_grant, 1'b0);
        check("rst_i2c_start", i2c_start, 1'b0);
        check("rst_i2c_addr", i2c_slave_addr, 7'h00);
        check("rst_c0_tx", c0_tx_data_req, 1'b0);
        check("rst_c1_rx", c1_rx_data_ready, 1'b0);
        check("rst_c0_rdata", c0_read_data, 8'h3C);
        check("rst_c1_rdata", c1_read_data, 8'h3C);
        c0_start = 1'b0; c1_start = 1'b0;
        i2c_tx_data_req = 1'b0; i2c_rx_data_ready = 1'b0;
        reset = 1'b0;
        tick(2);

        // Single request from client 0: grant two edges after start rises.
        push(0, 0, cyc + 2);
        c0_start = 1'b1;
        tick(1);
        check("lat_c0_grant_early", c0_grant, 1'b0);
        check("lat_i2c_start_early", i2c_start, 1'b0);
        tick(1);
        check("a_c0_grant", c0_grant, 1'b1);
        check("a_i2c_start", i2c_start, 1'b1);
        check("a_i2c_addr", i2c_slave_addr, 7'h50);
        check("a_i2c_nbytes", i2c_nbytes, 8'd2);
        check("a_i2c_wdata", i2c_write_data, 8'h11);
        check("a_c1_grant", c1_grant, 1'b0);
        c0_start = 1'b0;
        tick(6);

        // Fresh reset so client 0 is favoured again.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);

        // Simultaneous requests: client 0 first, then 4-cycle gap, then client 1.
        push(0, 0, cyc + 2);
        c0_start = 1'b1;
        c1_start = 1'b1;
        tick(4);
        check("b_c0_grant", c0_grant, 1'b1);
        check("b_c1_grant", c1_grant, 1'b0);
        r = cyc;
        c0_start = 1'b0;
        push(0, 1, r + 7);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (i2c_start || c0_grant || c1_grant) bad++;
        end
        check("b_gap_quiet_cycles", bad, 0);
        tick(1);
        check("b_c1_grant", c1_grant, 1'b1);
        check("b_i2c_addr", i2c_slave_addr, 7'h2A);
        check("b_i2c_rw", i2c_rw, 1'b1);
        check("b_i2c_nbytes", i2c_nbytes, 8'd3);
        check("b_i2c_start", i2c_start, 1'b1);

        // Master returns routed only to the granted client.
        i2c_tx_data_req = 1'b1;
        #1;
        check("c_c1_tx", c1_tx_data_req, 1'b1);
        check("c_c0_tx", c0_tx_data_req, 1'b0);
        i2c_rx_data_ready = 1'b1;
        i2c_read_data = 8'hA5;
        #1;
        check("c_c1_rx", c1_rx_data_ready, 1'b1);
        check("c_c0_rx", c0_rx_data_ready, 1'b0);
        check("c_c0_rdata", c0_read_data, 8'hA5);
        check("c_c1_rdata", c1_read_data, 8'hA5);
        i2c_tx_data_req = 1'b0;
        i2c_rx_data_ready = 1'b0;

        // Repeated start on client 0 keeps the grant; client 1 waits.
        c1_start = 1'b0;
        tick(7);
        c0_rw = 1'b0;
        push(0, 0, cyc + 2);
        c0_start = 1'b1;
        tick(3);
        c1_start = 1'b1;
        tick(1);
        c0_rw = 1'b1;
        tick(4);
        check("d_c0_grant_kept", c0_grant, 1'b1);
        check("d_c1_grant", c1_grant, 1'b0);
        check("d_i2c_rw", i2c_rw, 1'b1);
        r = cyc;
        c0_start = 1'b0;
        push(0, 1, r + 7);
        tick(8);
        check("d_c1_grant_after", c1_grant, 1'b1);
        c1_start = 1'b0;
        tick(7);

        // Watchdog: client 0 holds start; pulse at grant cycle 16, no regrant until toggled.
        c0_rw = 1'b0;
        s = cyc;
        push(0, 0, s + 2);
        push(1, 0, s + 16);
        c0_start = 1'b1;
        tick(16);
        check("e_c0_timeout", c0_timeout, 1'b1);
        tick(1);
        check("e_c0_grant_aborted", c0_grant, 1'b0);
        check("e_c0_timeout_once", c0_timeout, 1'b0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (c0_grant || c1_grant) bad++;
        end
        check("e_no_regrant", bad, 0);
        c0_start = 1'b0;
        tick(1);
        t = cyc;
        push(0, 0, t + 2);
        c0_start = 1'b1;
        // Release exactly in the expiry cycle: normal release, no pulse.
        tick(16);
        c0_start = 1'b0;
        #1;
        check("e_release_no_timeout", c0_timeout, 1'b0);
        tick(1);
        check("e_release_grant", c0_grant, 1'b0);
        tick(6);

        // Reset during GRANT1: outputs drop at once; client 0 wins afterwards.
        c1_start = 1'b1;
        push(0, 1, cyc + 2);
        tick(3);
        check("f_c1_grant", c1_grant, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("f_rst_c1_grant", c1_grant, 1'b0);
        check("f_rst_i2c_start", i2c_start, 1'b0);
        check("f_rst_i2c_addr", i2c_slave_addr, 7'h00);
        check("f_rst_i2c_rw", i2c_rw, 1'b0);
        c0_start = 1'b1;
        tick(1);
        reset = 1'b0;
        push(0, 0, cyc + 2);
        tick(2);
        check("f_c0_grant", c0_grant, 1'b1);
        check("f_c1_grant", c1_grant, 1'b0);
        c0_start = 1'b0;
        c1_start = 1'b0;
        tick(8);

        check("sb_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 4: idle cycles with i2c_start held 0 between grants, so the master can issue STOP; range 1..255.
REQ-002 Parameter TIMEOUT, default 0: maximum cycles per grant; 0 disables the watchdog; counter is 24 bits.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-005 cN_slave_addr  in  7  client N (N=0,1) target slave address.
REQ-006 cN_rw  in  1  client N direction, 1=read, 0=write.
REQ-007 cN_write_data  in  8  client N tx byte.
REQ-008 cN_nbytes  in  8  client N transfer length.
REQ-009 cN_start  in  1  client N request, and transaction-active level.
REQ-010 cN_read_data  out  8  rx byte, broadcast from i2c_read_data.
REQ-011 cN_tx_data_req  out  1  i2c_tx_data_req gated by the client N grant.
REQ-012 cN_rx_data_ready  out  1  i2c_rx_data_ready gated by the client N grant.
REQ-013 cN_grant  out  1  client N currently owns the master.
REQ-014 cN_timeout  out  1  one-cycle pulse: the client N grant was aborted by the watchdog.
REQ-015 i2c_slave_addr/i2c_rw/i2c_write_data/i2c_nbytes  out  7/1/8/8  muxed from the granted client; 0 when no grant.
REQ-016 i2c_start  out  1  granted client's cN_start AND the grant is live; 0 otherwise.
REQ-017 i2c_read_data  in  8; i2c_tx_data_req  in  1; i2c_rx_data_ready  in  1: returns from the master.

Function
REQ-018 FSM states: IDLE, GRANT0, GRANT1, GAP; the state is registered; outputs are combinational decode of the state plus the muxed inputs.
REQ-019 IDLE: if exactly one client has cN_start=1 and its armed flag is set, enter GRANTN on the next edge.
REQ-020 IDLE, both clients armed and requesting: round-robin; grant the client not granted last; after reset, client 0 wins first.
REQ-021 GRANTN: hold the grant while cN_start=1, including across repeated-start rw changes; the other client's requests are ignored.
REQ-022 GRANTN, cN_start falls to 0: enter GAP on the next edge; load the gap counter with GAP_CYCLES.
REQ-023 GAP: decrement each cycle; enter IDLE when the count reaches 1; total GAP_CYCLES cycles with no grant.
REQ-024 The grant takes effect the cycle after entry to GRANTN, so a request is first forwarded to i2c_start two edges after cN_start rises.
REQ-025 Watchdog (TIMEOUT>0): count cycles in GRANTN; on reaching TIMEOUT, pulse cN_timeout, clear armed[N], enter GAP.
REQ-026 armed[N] is set whenever cN_start=0; a client whose grant was aborted is regranted only after it drops and then reraises start.
REQ-027 cN_tx_data_req and cN_rx_data_ready are 0 for the non-granted client regardless of master activity.
REQ-028 cN_start deasserting in the same cycle the watchdog expires: treat as a normal release (no timeout pulse).
REQ-029 Requests arriving during GAP are held pending (level-sensitive) and arbitrated on IDLE entry.

Reset
REQ-030 Reset clears: state=IDLE, last-granted=1 (client 0 favoured), armed=2'b11, all counters=0.
REQ-031 While reset is asserted: every output = 0 except cN_read_data, which follows i2c_read_data.
REQ-032 Reset mid-grant: i2c_start drops asynchronously the same cycle; after release, a request still held high is regranted normally.

Verification
REQ-033 c0_start=1 alone, c0_nbytes=2, c0_slave_addr=7'h50 -> c0_grant=1 two edges later; i2c_slave_addr=7'h50, i2c_nbytes=2, i2c_start=1.
REQ-034 c0_start and c1_start rise together after reset -> client 0 granted; after it releases, GAP lasts 4 cycles with i2c_start=0, then client 1 is granted.
REQ-035 Client 1 granted, i2c_tx_data_req=1 -> c1_tx_data_req=1 and c0_tx_data_req=0; i2c_rx_data_ready=1, i2c_read_data=8'hA5 -> only c1_rx_data_ready=1, both read_data=8'hA5.
REQ-036 TIMEOUT=16, c0_start held high -> c0_timeout pulses once at grant cycle 16, then GAP, then no regrant until c0_start toggles 0->1.
REQ-037 Client 0 granted, rw switches 0->1 with start held (repeated start) -> grant retained, client 1's pending request is not granted.
REQ-038 reset pulsed during GRANT1 -> all outputs 0 immediately; after release, with both requesting, client 0 is granted.
